// File: rtl/ofs_fim_eth_if_pkg.sv
// Shared Ethernet/PTP interface types for the FIM HSSI path.
// Provides the 96-bit PTP Time-of-Day layout, the nanosecond rollover
// modulus and the TOD generator FSM state type.
package ofs_fim_eth_if_pkg;

  localparam int unsigned PTP_TOD_W = 96;
  localparam logic [31:0] PTP_NS_PER_SEC = 32'd1_000_000_000;

  // Field order matches the on-wire TOD: [95:48] sec, [47:16] ns, [15:0] fns.
  typedef struct packed {
    logic [47:0] sec;
    logic [31:0] ns;
    logic [15:0] fns;
  } t_ptp_tod;

  typedef enum logic [1:0] {
    StUnsync  = 2'd0,
    StRun     = 2'd1,
    StAdjPend = 2'd2
  } t_tod_state;

endpackage

// File: rtl/ofs_fim_ptp_tod_add.sv
// Combinational next-TOD calculator.
// Adds the per-clock increment to {ns,fns}, optionally adds a signed ns offset,
// then normalizes the ns field once into [0, NS_PER_SEC) with carry/borrow into
// the seconds field (seconds wrap modulo 2^48).
// Ports:
//   i_tod      current TOD
//   i_inc_ns   increment, integer ns
//   i_inc_fns  increment, fractional ns
//   i_adj_en   apply the offset this cycle
//   i_adj_neg  offset sign (1 = subtract)
//   i_adj_ns   offset magnitude in ns
//   o_tod      normalized next TOD
module ofs_fim_ptp_tod_add
  import ofs_fim_eth_if_pkg::*;
#(
  parameter logic [31:0] NS_PER_SEC = PTP_NS_PER_SEC
) (
  input  t_ptp_tod    i_tod,
  input  logic [3:0]  i_inc_ns,
  input  logic [15:0] i_inc_fns,
  input  logic        i_adj_en,
  input  logic        i_adj_neg,
  input  logic [31:0] i_adj_ns,
  output t_ptp_tod    o_tod
);

  logic [51:0]        w_sum;
  logic [35:0]        w_ns_sum;
  logic signed [37:0] w_off;
  logic signed [37:0] w_ns_tot;
  logic signed [37:0] w_mod;
  logic [31:0]        w_ns_lo;

  assign w_mod = $signed({6'd0, NS_PER_SEC});

  always_comb begin
    // 48-bit {ns,fns} sum with a 4-bit guard so the ns carry is never lost.
    w_sum    = {4'd0, i_tod.ns, i_tod.fns} + {32'd0, i_inc_ns, i_inc_fns};
    w_ns_sum = w_sum[51:16];
    w_off    = '0;
    if (i_adj_en) begin
      w_off = i_adj_neg ? -$signed({6'd0, i_adj_ns}) : $signed({6'd0, i_adj_ns});
    end
    w_ns_tot = $signed({2'b00, w_ns_sum}) + w_off;
    w_ns_lo  = w_ns_tot[31:0];

    o_tod.fns = w_sum[15:0];
    o_tod.sec = i_tod.sec;
    o_tod.ns  = w_ns_lo;
    // Normalized results always fit in 32 bits, so 32-bit wrap arithmetic is exact.
    if (w_ns_tot[37]) begin
      o_tod.ns  = w_ns_lo + NS_PER_SEC;
      o_tod.sec = i_tod.sec - 48'd1;
    end else if (w_ns_tot >= w_mod) begin
      o_tod.ns  = w_ns_lo - NS_PER_SEC;
      o_tod.sec = i_tod.sec + 48'd1;
    end
  end

endmodule

// File: rtl/ofs_fim_hssi_ptp_tod_gen.sv
// Client-side PTP Time-of-Day generator for the HSSI TX/RX TOD interfaces.
// Holds a free-running 96-bit TOD that can be loaded, slewed by a signed ns
// offset (two-stage: register, then apply on the next tick) and retuned via
// the per-clock increment.
// Ports:
//   clk, rst                    MAC clock, async active-high reset
//   period_wr/ns/fns            strobe + new per-clock increment
//   load_valid/ready, load_tod  absolute TOD set handshake (ready always 1)
//   adj_valid/ready/neg/ns      offset adjust handshake
//   adj_err                     one-cycle pulse on a rejected adjust
//   tod_synced                  set by the first accepted load
//   tx_/rx_tod_tvalid/tdata     TOD outputs (tdata = TOD register)
module ofs_fim_hssi_ptp_tod_gen
  import ofs_fim_eth_if_pkg::*;
#(
  parameter logic [3:0]  DEFAULT_INC_NS  = 4'd2,
  parameter logic [15:0] DEFAULT_INC_FNS = 16'h7B42,
  parameter logic [31:0] NS_PER_SEC      = PTP_NS_PER_SEC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 period_wr,
  input  logic [3:0]           period_ns,
  input  logic [15:0]          period_fns,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [PTP_TOD_W-1:0] load_tod,
  input  logic                 adj_valid,
  output logic                 adj_ready,
  input  logic                 adj_neg,
  input  logic [31:0]          adj_ns,
  output logic                 adj_err,
  output logic                 tod_synced,
  output logic                 tx_tod_tvalid,
  output logic [PTP_TOD_W-1:0] tx_tod_tdata,
  output logic                 rx_tod_tvalid,
  output logic [PTP_TOD_W-1:0] rx_tod_tdata
);

  t_tod_state  r_state;
  t_tod_state  w_state_nxt;
  t_ptp_tod    r_tod;
  t_ptp_tod    w_tod_tick;
  logic [3:0]  r_inc_ns;
  logic [15:0] r_inc_fns;
  logic        r_synced;
  logic        r_adj_err;
  logic        r_adj_neg;
  logic [31:0] r_adj_ns;
  logic        w_adj_ready;
  logic        w_adj_fire;
  logic        w_adj_bad;
  logic        w_adj_good;

  always_comb begin
    // A concurrent load takes priority, so the adjust must not be consumed.
    w_adj_ready = (r_state == StRun) && !load_valid;
    w_adj_fire  = adj_valid && w_adj_ready;
    w_adj_bad   = w_adj_fire && (adj_ns >= NS_PER_SEC);
    w_adj_good  = w_adj_fire && !w_adj_bad;

    w_state_nxt = r_state;
    if (load_valid) begin
      w_state_nxt = StRun;
    end else begin
      unique case (r_state)
        StUnsync:  w_state_nxt = StUnsync;
        StRun:     if (w_adj_good) w_state_nxt = StAdjPend;
        StAdjPend: w_state_nxt = StRun;
        default:   w_state_nxt = StUnsync;
      endcase
    end
  end

  ofs_fim_ptp_tod_add #(
    .NS_PER_SEC (NS_PER_SEC)
  ) u_tod_add (
    .i_tod     (r_tod),
    .i_inc_ns  (r_inc_ns),
    .i_inc_fns (r_inc_fns),
    .i_adj_en  (r_state == StAdjPend),
    .i_adj_neg (r_adj_neg),
    .i_adj_ns  (r_adj_ns),
    .o_tod     (w_tod_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StUnsync;
      r_tod     <= '0;
      r_inc_ns  <= DEFAULT_INC_NS;
      r_inc_fns <= DEFAULT_INC_FNS;
      r_synced  <= 1'b0;
      r_adj_err <= 1'b0;
      r_adj_neg <= 1'b0;
      r_adj_ns  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tod     <= load_valid ? t_ptp_tod'(load_tod) : w_tod_tick;
      r_synced  <= r_synced | load_valid;
      r_adj_err <= w_adj_bad;
      if (period_wr) begin
        r_inc_ns  <= period_ns;
        r_inc_fns <= period_fns;
      end
      if (w_adj_good) begin
        r_adj_neg <= adj_neg;
        r_adj_ns  <= adj_ns;
      end
    end
  end

  assign load_ready    = 1'b1;
  assign adj_ready     = w_adj_ready;
  assign adj_err       = r_adj_err;
  assign tod_synced    = r_synced;
  assign tx_tod_tvalid = r_synced;
  assign rx_tod_tvalid = r_synced;
  assign tx_tod_tdata  = r_tod;
  assign rx_tod_tdata  = r_tod;

endmodule
